muldiv_hilo_unit: RTL and testbench
===================================

Name: muldiv_hilo_unit

Overview:
- Iterative multiply/divide engine with architectural HI/LO registers for the pipelined MIPS core.
- Sits beside the EX-stage ALU and serves MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Drives a stall request back to the hazard/control logic while a multi-cycle operation is in flight.
- Parametrised in operand width, which the single-cycle Div/Mfhi datapath path cannot handle.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits. One iteration per cycle, so latency is WIDTH+1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- Start  in  1  request a new operation (EX stage, instruction valid).
- Op  in  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU.
- OpA  in  WIDTH  rs operand (multiplicand/dividend).
- OpB  in  WIDTH  rt operand (multiplier/divisor).
- ReadHiLo  in  1  MFHI/MFLO in EX wants HI/LO.
- MthiWe  in  1  write WrData to HI.
- MtloWe  in  1  write WrData to LO.
- WrData  in  WIDTH  data for MTHI/MTLO.
- Flush  in  1  abort the in-flight operation (exception/branch kill).
- Busy  out  1  operation in progress.
- Stall  out  1  stall request to pipeline.
- Done  out  1  one-cycle pulse; HI/LO hold the new result.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.

Behaviour:
- Reset: HI=0, LO=0, Busy=0, Done=0, Stall=0, state=IDLE. Reset overrides everything, including mid-operation; HI/LO are cleared.
- States: IDLE, RUN, FIN.
- IDLE with Start=1, accepted at edge E0:
  - Latch the operands; for signed ops, latch absolute values and result sign bits.
  - Load iteration count = WIDTH; go to RUN.
- RUN:
  - One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - Go to FIN after WIDTH cycles.
- FIN:
  - Apply sign correction:
    - Signed multiply: negate the 2*WIDTH product when the operand signs differ.
    - Signed divide: quotient negated when the operand signs differ; remainder takes the dividend's sign.
  - At edge E(WIDTH+1): write HI (product upper half / remainder) and LO (product lower half / quotient), go to IDLE, Done=1 for the following cycle.
- Busy=1 in RUN and FIN only.
- Stall = Busy & (Start | ReadHiLo | MthiWe | MtloWe). Combinational, no registered delay.
- Stalled requests are ignored by this block; the pipeline re-presents them.
- Start in the same cycle that Done=1 is high (IDLE) is accepted normally, giving back-to-back operations.
- MTHI/MTLO in IDLE: HI/LO written at the next edge. MthiWe and MtloWe may both be asserted in the same cycle. If Start is also asserted, the MT write takes effect first and the operation's result later overwrites it.
- Divide by zero: no trap and no hang; full latency is still used.
  - DIVU: HI=OpA, LO=all ones.
  - DIV: HI=OpA, LO = all ones if OpA≥0, else 1.
- DIV of most-negative by -1: LO=most-negative, HI=0.
- Flush while Busy: at the next edge go to IDLE and Busy=0. HI/LO are unchanged and Done is not pulsed. Flush in IDLE has no effect.
- Flush and Start in the same IDLE cycle: Start is dropped.
- HI/LO outputs are registers; they never show intermediate values.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- Defined: in multiply RUN, once the remaining shifted multiplier is zero, go to FIN on the next edge. Latency becomes 2 + (index of highest set bit of |OpB|), with a minimum of 2 edges; multiply by 0 takes 2 edges. Divide latency is unchanged.
- Undefined: multiply is fixed at WIDTH+1 edges. The early-exit comparator is not built.

Test Plan:
- MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001, Done exactly 33 edges after accept, Busy high for 33 cycles.
- MULT -3×5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV -7÷2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100÷0 → HI=0x00000064, LO=0xFFFFFFFF. DIV 0x80000000÷0xFFFFFFFF → LO=0x80000000, HI=0; no hang.
- While Busy, assert ReadHiLo, then Start, then MthiWe → Stall=1 each cycle and HI/LO unchanged. After Done, MTLO 0x1234 → LO=0x1234 next cycle.
- MULTU 6×7 with Flush at cycle 10 → Busy=0 next cycle, no Done, HI/LO keep their prior values. Then a new DIVU 42÷5 → LO=8, HI=2. Assert reset at cycle 5 of another op → HI=LO=0, Busy=0.
- With MULDIV_EARLY_TERM_EN: MULTU 0x10×0x3 → LO=0x30, Done 3 edges after accept. Without the macro, the same op takes 33 edges.

Source files
------------

// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: iterative radix-2 MIPS multiply/divide with architectural HI/LO.
// Define MULDIV_EARLY_TERM_EN to let multiply finish once the remaining multiplier is zero.
module muldiv_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic             ReadHiLo,
    input  logic             MthiWe,
    input  logic             MtloWe,
    input  logic [WIDTH-1:0] WrData,
    input  logic             Flush,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               is_div, neg_q, neg_r;
    logic [2*WIDTH-1:0] acc, mcand, prod_s;
    logic [WIDTH-1:0]   q, d, a_abs, b_abs, rem_s, quo_s;
    logic [WIDTH:0]     diff;
    logic               sa, sb, ge, early, last;

    assign Busy  = state != IDLE;
    assign Stall = Busy & (Start | ReadHiLo | MthiWe | MtloWe);

`ifdef MULDIV_EARLY_TERM_EN
    assign early = ~is_div && (q >> 1) == '0;
`else
    assign early = 1'b0;
`endif

    // Divide keeps {remainder, quotient} in acc; a quotient bit is set when the trial subtract does not borrow.
    always_comb begin
        sa     = ~Op[0] & OpA[WIDTH-1];
        sb     = ~Op[0] & OpB[WIDTH-1];
        a_abs  = sa ? -OpA : OpA;
        b_abs  = sb ? -OpB : OpB;
        diff   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, d};
        ge     = ~diff[WIDTH];
        prod_s = neg_q ? -acc : acc;
        rem_s  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        quo_s  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        last   = cnt == CW'(1) || early;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            q      <= '0;
            d      <= '0;
            Done   <= 1'b0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            Done <= 1'b0;
            if (state == IDLE) begin
                if (MthiWe) HI <= WrData;
                if (MtloWe) LO <= WrData;
                if (Start && !Flush) begin
                    state  <= RUN;
                    cnt    <= CW'(WIDTH);
                    is_div <= Op[1];
                    neg_q  <= sa ^ sb;
                    neg_r  <= sa;
                    acc    <= Op[1] ? {{WIDTH{1'b0}}, a_abs} : '0;
                    mcand  <= {{WIDTH{1'b0}}, a_abs};
                    q      <= b_abs;
                    d      <= b_abs;
                end
            end else if (Flush) begin
                state <= IDLE;
            end else if (state == RUN) begin
                cnt <= cnt - CW'(1);
                if (last) state <= FIN;
                if (is_div) begin
                    acc <= {ge ? diff[WIDTH-1:0] : acc[2*WIDTH-2:WIDTH-1], acc[WIDTH-2:0], ge};
                end else begin
                    if (q[0]) acc <= acc + mcand;
                    mcand <= mcand << 1;
                    q     <= q >> 1;
                end
            end else begin
                state <= IDLE;
                Done  <= 1'b1;
                HI    <= is_div ? rem_s : prod_s[2*WIDTH-1:WIDTH];
                LO    <= is_div ? quo_s : prod_s[WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb_muldiv_hilo_unit: directed vectors with a Done-driven scoreboard for muldiv_hilo_unit.
// Latency expectations follow MULDIV_EARLY_TERM_EN when it is defined for the build.
module tb_muldiv_hilo_unit;
    logic        clock, reset, Start, ReadHiLo, MthiWe, MtloWe, Flush;
    logic [1:0]  Op;
    logic [31:0] OpA, OpB, WrData, HI, LO;
    logic        Busy, Stall, Done;

    int          total = 0;
    int          bad = 0;
    logic [63:0] sbq[$];
    logic [31:0] m_hi = 0;
    logic [31:0] m_lo = 0;

    muldiv_hilo_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
        .ReadHiLo(ReadHiLo), .MthiWe(MthiWe), .MtloWe(MtloWe), .WrData(WrData),
        .Flush(Flush), .Busy(Busy), .Stall(Stall), .Done(Done), .HI(HI), .LO(LO)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Every Done pulse retires the oldest expected result.
    always @(negedge clock) begin
        if (!reset && Done) begin
            check("done_pending", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
                logic [63:0] e;
                e = sbq.pop_front();
                check("result_hi", HI, e[63:32]);
                check("result_lo", LO, e[31:0]);
                m_hi = e[63:32];
                m_lo = e[31:0];
            end
        end
    end

    function automatic int mul_lat(input logic [31:0] babs);
`ifdef MULDIV_EARLY_TERM_EN
        int k;
        k = 0;
        for (int i = 0; i < 32; i++) if (babs[i]) k = i;
        return 2 + k;
`else
        return (babs == babs) ? 33 : 0;
`endif
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] hi, input logic [31:0] lo);
        Start = 1; Op = op; OpA = a; OpB = b;
        if (push) sbq.push_back({hi, lo});
        @(posedge clock); #1;
        Start = 0;
    endtask

    task automatic wait_done(input int lat, input bit chk);
        int n;
        int bc;
        n = 0;
        bc = Busy ? 1 : 0;
        while (!Done && n < 200) begin
            @(posedge clock); #1;
            n++;
            if (Busy) bc++;
        end
        check("done_seen", Done, 1);
        if (chk) begin
            check("latency", n, lat);
            check("busy_cycles", bc, lat);
        end
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo, input int lat);
        issue(op, a, b, 1, hi, lo);
        wait_done(lat, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1);
    end

    initial begin
        reset = 1; Start = 0; Op = 0; OpA = 0; OpB = 0;
        ReadHiLo = 0; MthiWe = 0; MtloWe = 0; WrData = 0; Flush = 0;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_stall", Stall, 0);
        @(posedge clock); #1;

        run(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, mul_lat(32'hFFFFFFFF));
        run(2'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, mul_lat(32'd5));
        run(2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        run(2'd3, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, 33);
        run(2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33);
        run(2'd2, 32'hFFFFFFF8, 32'd0, 32'hFFFFFFF8, 32'h1, 33);
        run(2'd2, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 33);
        run(2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, mul_lat(32'h80000000));
        run(2'd0, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, mul_lat(32'd1));
        run(2'd2, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 33);
        run(2'd1, 32'h10, 32'h3, 32'h0, 32'h30, mul_lat(32'h3));
        run(2'd1, 32'd5, 32'd0, 32'h0, 32'h0, mul_lat(32'd0));

        // Requests presented while busy must stall and leave HI/LO alone.
        issue(2'd3, 32'd1000, 32'd7, 1, 32'd6, 32'h8E);
        ReadHiLo = 1;
        @(negedge clock); check("stall_read", Stall, 1);
        @(posedge clock); #1; ReadHiLo = 0;
        check("busy_hi_keep", HI, m_hi);
        check("busy_lo_keep", LO, m_lo);
        Start = 1; Op = 2'd1; OpA = 2; OpB = 2;
        @(negedge clock); check("stall_start", Stall, 1);
        @(posedge clock); #1; Start = 0;
        MthiWe = 1; WrData = 32'hDEAD;
        @(negedge clock); check("stall_mthi", Stall, 1);
        @(posedge clock); #1; MthiWe = 0;
        check("mthi_ignored", HI, m_hi);
        @(negedge clock); check("stall_quiet", Stall, 0);
        wait_done(0, 0);
        MtloWe = 1; WrData = 32'h1234;
        @(posedge clock); #1; MtloWe = 0;
        check("mtlo_lo", LO, 32'h1234);
        check("mtlo_hi", HI, 32'd6);
        m_lo = 32'h1234;
        ReadHiLo = 1;
        @(negedge clock); check("stall_idle", Stall, 0);
        @(posedge clock); #1; ReadHiLo = 0;

        issue(2'd1, 32'd6, 32'd7, 0, 0, 0);
`ifdef MULDIV_EARLY_TERM_EN
        repeat (1) @(posedge clock);
`else
        repeat (9) @(posedge clock);
`endif
        #1;
        check("busy_before_flush", Busy, 1);
        Flush = 1;
        @(posedge clock); #1; Flush = 0;
        check("flush_busy", Busy, 0);
        repeat (40) @(posedge clock);
        #1;
        check("flush_hi", HI, m_hi);
        check("flush_lo", LO, m_lo);
        Start = 1; Flush = 1; Op = 2'd3; OpA = 42; OpB = 5;
        @(posedge clock); #1; Start = 0; Flush = 0;
        check("flush_drops_start", Busy, 0);

        run(2'd3, 32'd42, 32'd5, 32'd2, 32'd8, 33);

        MthiWe = 1; WrData = 32'h5555;
        issue(2'd3, 32'd9, 32'd4, 1, 32'd1, 32'd2);
        MthiWe = 0;
        check("mt_with_start", HI, 32'h5555);
        wait_done(33, 1);

        MthiWe = 1; MtloWe = 1; WrData = 32'hA5A5;
        @(posedge clock); #1; MthiWe = 0; MtloWe = 0;
        check("mt_both_hi", HI, 32'hA5A5);
        check("mt_both_lo", LO, 32'hA5A5);

        issue(2'd3, 32'd42, 32'd5, 0, 0, 0);
        repeat (4) @(posedge clock);
        #1 reset = 1;
        @(posedge clock); #1; reset = 0;
        check("midop_rst_hi", HI, 0);
        check("midop_rst_lo", LO, 0);
        check("midop_rst_busy", Busy, 0);
        check("midop_rst_done", Done, 0);
        repeat (40) @(posedge clock);
        #1;
        check("scoreboard_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
